mem_access_stage: RTL and testbench

Memory-access stage of the RISC core; sits directly downstream of the EXE/MEM pipeline latch and consumes its held outputs. Executes loads, stores and I/O transfers over the 8-bit system bus, splitting 16-bit accesses into two byte cycles, and stalls the upstream pipeline until the access completes. Registered results (write-back id, flags, data) feed the write-back stage.

---
 rtl/mem_access_stage.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: runs loads, stores and I/O transfers over the 8-bit system bus,
// splitting 16-bit accesses into two byte cycles and stalling upstream until completion.
module mem_access_stage (
  input  logic        CLK,
  input  logic        RST,
  // EXE/MEM latch outputs
  input  logic [4:0]  Wr_id_in,
  input  logic [7:0]  Fmask_in,
  input  logic [7:0]  Flags_in,
  input  logic        EOI_in,
  input  logic [6:0]  MEMctrl_in,
  input  logic [15:0] Result_in,
  input  logic [15:0] Src1_in,
  input  logic [15:0] seqNPC_in,
  // System bus
  input  logic [7:0]  Bus_rdata,
  input  logic        Bus_ack,
  output logic        Bus_req,
  output logic        Bus_rd,
  output logic        Bus_wr,
  output logic        Bus_io,
  output logic [15:0] Bus_addr,
  output logic [7:0]  Bus_wdata,
  // Pipeline control and write-back
  output logic        Stall_out,
  output logic [4:0]  Wr_id_out,
  output logic [7:0]  Fmask_out,
  output logic [7:0]  Flags_out,
  output logic        EOI_out,
  output logic [15:0] Data_out,
  output logic        Valid_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
  localparam logic [1:0] ACC1 = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_q, state_d;

  logic        access_op;
  logic        is_read;
  logic        is_io;
  logic        is_word;
  logic [15:0] store_data;
  logic        ack_valid;
  logic        load_out;
  logic        unused_ctrl;

  logic        bus_req_q, bus_req_d;
  logic        bus_rd_q, bus_rd_d;
  logic        bus_wr_q, bus_wr_d;
  logic        bus_io_q, bus_io_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;

  logic [7:0]  byte0_q, byte1_q;

  logic [4:0]  wr_id_q;
  logic [7:0]  fmask_q;
  logic [7:0]  flags_q;
  logic        eoi_q;
  logic [15:0] data_q, data_d;
  logic        valid_q;

  assign unused_ctrl = MEMctrl_in[5];

  // Read wins over write; memory space wins over I/O space within the chosen direction.
  always_comb begin
    access_op  = |MEMctrl_in[3:0];
    is_read    = MEMctrl_in[0] | MEMctrl_in[2];
    is_io      = is_read ? ~MEMctrl_in[0] : ~MEMctrl_in[1];
    is_word    = MEMctrl_in[4];
    store_data = MEMctrl_in[6] ? seqNPC_in : Src1_in;
  end

  // Bus_req mirrors ACC0/ACC1, so an ack outside an access cycle never advances the FSM.
  assign ack_valid = Bus_ack & bus_req_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (access_op) begin
          state_d = ACC0;
        end
      end
      ACC0: begin
        if (ack_valid) begin
          state_d = is_word ? ACC1 : DONE;
        end
      end
      ACC1: begin
        if (ack_valid) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the stall low as well, so every output reads zero while RST is held.
  assign Stall_out = RST & (((state_q == IDLE) & access_op) | (state_q == ACC0) |
                            (state_q == ACC1));

  assign load_out = ~Stall_out;

  // Bus outputs are registered from the next state so they are valid throughout ACC0/ACC1.
  always_comb begin
    bus_req_d   = 1'b0;
    bus_rd_d    = 1'b0;
    bus_wr_d    = 1'b0;
    bus_io_d    = 1'b0;
    bus_addr_d  = 16'h0000;
    bus_wdata_d = 8'h00;
    if ((state_d == ACC0) || (state_d == ACC1)) begin
      bus_req_d = 1'b1;
      bus_rd_d  = is_read;
      bus_wr_d  = ~is_read;
      bus_io_d  = is_io;
      if (state_d == ACC1) begin
        bus_addr_d  = Result_in + 16'd1;
        bus_wdata_d = is_read ? 8'h00 : store_data[15:8];
      end else begin
        bus_addr_d  = Result_in;
        bus_wdata_d = is_read ? 8'h00 : store_data[7:0];
      end
    end
  end

  always_comb begin
    data_d = Result_in;
    if (access_op && is_read) begin
      data_d = is_word ? {byte1_q, byte0_q} : {8'h00, byte0_q};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_io_q    <= 1'b0;
      bus_addr_q  <= 16'h0000;
      bus_wdata_q <= 8'h00;
      byte0_q     <= 8'h00;
      byte1_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_rd_q    <= bus_rd_d;
      bus_wr_q    <= bus_wr_d;
      bus_io_q    <= bus_io_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if (ack_valid && bus_rd_q && (state_q == ACC0)) begin
        byte0_q <= Bus_rdata;
      end
      if (ack_valid && bus_rd_q && (state_q == ACC1)) begin
        byte1_q <= Bus_rdata;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_id_q <= 5'd0;
      fmask_q <= 8'h00;
      flags_q <= 8'h00;
      eoi_q   <= 1'b0;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
    end else if (load_out) begin
      wr_id_q <= Wr_id_in;
      fmask_q <= Fmask_in;
      flags_q <= Flags_in;
      eoi_q   <= EOI_in;
      data_q  <= data_d;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign Bus_req   = bus_req_q;
  assign Bus_rd    = bus_rd_q;
  assign Bus_wr    = bus_wr_q;
  assign Bus_io    = bus_io_q;
  assign Bus_addr  = bus_addr_q;
  assign Bus_wdata = bus_wdata_q;

  assign Wr_id_out = wr_id_q;
  assign Fmask_out = fmask_q;
  assign Flags_out = flags_q;
  assign EOI_out   = eoi_q;
  assign Data_out  = data_q;
  assign Valid_out = valid_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: acts as EXE/MEM latch and bus slave, checking against a
// transaction-level model of each instruction (bus cycles, stall length, write-back result).
module tb_mem_access_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  Wr_id_in;
  logic [7:0]  Fmask_in, Flags_in;
  logic        EOI_in;
  logic [6:0]  MEMctrl_in;
  logic [15:0] Result_in, Src1_in, seqNPC_in;
  logic [7:0]  Bus_rdata;
  logic        Bus_ack;
  logic        Bus_req, Bus_rd, Bus_wr, Bus_io;
  logic [15:0] Bus_addr;
  logic [7:0]  Bus_wdata;
  logic        Stall_out;
  logic [4:0]  Wr_id_out;
  logic [7:0]  Fmask_out, Flags_out;
  logic        EOI_out;
  logic [15:0] Data_out;
  logic        Valid_out;

  mem_access_stage dut (
    .CLK        (CLK),
    .RST        (RST),
    .Wr_id_in   (Wr_id_in),
    .Fmask_in   (Fmask_in),
    .Flags_in   (Flags_in),
    .EOI_in     (EOI_in),
    .MEMctrl_in (MEMctrl_in),
    .Result_in  (Result_in),
    .Src1_in    (Src1_in),
    .seqNPC_in  (seqNPC_in),
    .Bus_rdata  (Bus_rdata),
    .Bus_ack    (Bus_ack),
    .Bus_req    (Bus_req),
    .Bus_rd     (Bus_rd),
    .Bus_wr     (Bus_wr),
    .Bus_io     (Bus_io),
    .Bus_addr   (Bus_addr),
    .Bus_wdata  (Bus_wdata),
    .Stall_out  (Stall_out),
    .Wr_id_out  (Wr_id_out),
    .Fmask_out  (Fmask_out),
    .Flags_out  (Flags_out),
    .EOI_out    (EOI_out),
    .Data_out   (Data_out),
    .Valid_out  (Valid_out)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem [65536];
  logic [7:0]  iom [65536];
  logic [38:0] pending;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [38:0] out_vec();
    return {Valid_out, Wr_id_out, Fmask_out, Flags_out, EOI_out, Data_out};
  endfunction

  function automatic logic [67:0] all_vec();
    return {out_vec(), Stall_out, Bus_req, Bus_rd, Bus_wr, Bus_io, Bus_addr, Bus_wdata};
  endfunction

  // Entered and left on a falling edge; that falling edge is the instruction's first cycle.
  task automatic do_instr(input logic [6:0] ctrl, input logic [15:0] res, input logic [15:0] s1,
                          input logic [15:0] npc, input logic [4:0] id, input logic [7:0] fm,
                          input logic [7:0] fl, input logic e, input int w0, input int w1);
    logic        acc, rd, io, wd, last;
    logic [15:0] src, a, dexp;
    logic [7:0]  wb, rb;
    logic [7:0]  b [2];
    int          nb, wt;
    check("result", 96'(out_vec()), 96'(pending));
    MEMctrl_in = ctrl; Result_in = res; Src1_in = s1; seqNPC_in = npc;
    Wr_id_in = id; Fmask_in = fm; Flags_in = fl; EOI_in = e;
    acc = |ctrl[3:0];
    rd  = ctrl[0] | ctrl[2];
    io  = rd ? !ctrl[0] : !ctrl[1];
    wd  = ctrl[4];
    src = ctrl[6] ? npc : s1;
    b[0] = 8'h00; b[1] = 8'h00;
    #1;
    check("first_cycle", {Stall_out, Bus_req}, {acc, 1'b0});
    Bus_ack = 1'($urandom_range(0, 1));
    Bus_rdata = 8'($urandom);
    if (acc) begin
      nb = wd ? 2 : 1;
      for (int k = 0; k < nb; k++) begin
        a  = res + 16'(k);
        wb = (k == 0) ? src[7:0] : src[15:8];
        wt = (k == 0) ? w0 : w1;
        for (int j = 0; j <= wt; j++) begin
          @(negedge CLK);
          check("bus_cycle",
                {Stall_out, Bus_req, Bus_rd, Bus_wr, Bus_io, Bus_addr,
                 (rd ? 8'h00 : Bus_wdata), Valid_out},
                {1'b1, 1'b1, rd, !rd, io, a, (rd ? 8'h00 : wb), 1'b0});
          last = (j == wt);
          rb = io ? iom[a] : mem[a];
          Bus_ack = last;
          Bus_rdata = (last && rd) ? rb : 8'($urandom);
          if (last) begin
            if (rd) b[k] = rb;
            else if (io) iom[a] = wb;
            else mem[a] = wb;
          end
        end
      end
      @(negedge CLK);
      check("done_cycle", {Stall_out, Bus_req, Valid_out}, 3'b000);
      Bus_ack = 1'($urandom_range(0, 1));
      dexp = rd ? (wd ? {b[1], b[0]} : {8'h00, b[0]}) : res;
    end else begin
      dexp = res;
    end
    pending = {1'b1, id, fm, fl, e, dexp};
    @(negedge CLK);
  endtask

  // Word access (I/O read wins over writes) aborted by reset in its second byte cycle.
  task automatic abort_test();
    check("result", 96'(out_vec()), 96'(pending));
    MEMctrl_in = 7'b0011110; Result_in = 16'h00F0; Src1_in = 16'h5A5A; seqNPC_in = 16'h0;
    Wr_id_in = 5'd7; Fmask_in = 8'h11; Flags_in = 8'h22; EOI_in = 1'b1;
    #1;
    check("abort_idle", {Stall_out, Bus_req}, 2'b10);
    Bus_ack = 1'b0;
    @(negedge CLK);
    check("abort_acc0", {Stall_out, Bus_req, Bus_rd, Bus_wr, Bus_io, Bus_addr},
          {5'b11101, 16'h00F0});
    Bus_ack = 1'b1; Bus_rdata = iom[16'h00F0];
    @(negedge CLK);
    check("abort_acc1", {Stall_out, Bus_req, Bus_rd, Bus_wr, Bus_io, Bus_addr},
          {5'b11101, 16'h00F1});
    RST = 1'b0; Bus_ack = 1'b0;
    @(negedge CLK);
    check("abort_reset", 96'(all_vec()), 96'd0);
    RST = 1'b1;
    pending = '0;
  endtask

  initial begin
    logic [6:0]  c;
    logic [15:0] r;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      iom[i] = 8'($urandom);
    end
    mem[16'h8000] = 8'hA5;

    RST = 1'b0;
    MEMctrl_in = 7'b0000001; Result_in = 16'h4000; Src1_in = 16'h0; seqNPC_in = 16'h0;
    Wr_id_in = 5'd3; Fmask_in = 8'hFF; Flags_in = 8'h0F; EOI_in = 1'b1;
    Bus_ack = 1'b1; Bus_rdata = 8'h77;
    repeat (2) begin
      @(negedge CLK);
      check("reset_outputs", 96'(all_vec()), 96'd0);
    end
    RST = 1'b1;
    pending = '0;

    do_instr(7'b0000001, 16'h4000, 16'h0, 16'h0, 5'd3, 8'hFF, 8'h0F, 1'b1, 0, 0);
    do_instr(7'b0000000, 16'h1234, 16'h0, 16'h0, 5'd5, 8'h01, 8'h02, 1'b0, 0, 0);
    do_instr(7'b0000001, 16'h8000, 16'h0, 16'h0, 5'd9, 8'h03, 8'h04, 1'b0, 0, 0);
    do_instr(7'b0010001, 16'hFFFF, 16'h0, 16'h0, 5'd10, 8'h05, 8'h06, 1'b0, 2, 0);
    do_instr(7'b1010010, 16'h2000, 16'h1111, 16'hBEEF, 5'd11, 8'h07, 8'h08, 1'b1, 0, 0);
    do_instr(7'b0010001, 16'h2000, 16'h0, 16'h0, 5'd12, 8'h09, 8'h0A, 1'b0, 1, 1);
    abort_test();

    for (int n = 0; n < 300; n++) begin
      c = 7'($urandom);
      if ($urandom_range(0, 2) == 0) c[3:0] = 4'h0;
      r = 16'($urandom);
      if ($urandom_range(0, 7) == 0) r = 16'hFFFF;
      else if ($urandom_range(0, 3) == 0) r = {8'h00, r[7:0]};
      do_instr(c, r, 16'($urandom), 16'($urandom), 5'($urandom), 8'($urandom),
               8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)));
    end

    do_instr(7'b0000000, 16'h0000, 16'h0, 16'h0, 5'd0, 8'h00, 8'h00, 1'b0, 0, 0);
    check("bubble_result", 96'(out_vec()), 96'(pending));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
